vga_buf_arbiter: RTL and testbench

Single-port arbiter for the video buffer RAM shared by the scan-out reader and the CPU store path. It grants the RAM port to the VGA reader by priority. It recovers idle slots by reusing the last fetched word, since each 16-bit word holds two 8-bit pixels. It hands every free slot to the CPU through a req/ack handshake. It sits between `vga_display`, the CPU memory-mapped video window and the video buffer block RAM.

---
 rtl/vga_buf_arbiter_pkg.sv | 13 +
 rtl/vga_buf_arbiter_if.sv | 22 ++
 rtl/vga_buf_guard.sv | 20 ++
 rtl/vga_buf_arbiter.sv | 124 ++++++++++++
 tb/tb_vga_buf_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_buf_arbiter_pkg.sv
// rtl/vga_buf_arbiter_pkg.sv - buffer geometry and arbiter state encodings
package vga_buf_arbiter_pkg;

    localparam int unsigned VGA_BUF1_START = 32'h0000_4000;
    localparam int unsigned VGA_BUF2_START = 32'h0000_6000;
    localparam int unsigned VGA_BUF_WORDS  = 16 * 640 / 2;

    typedef enum logic [0:0] {
        ARB_IDLE    = 1'b0,
        ARB_CPU_ACK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/vga_buf_arbiter_if.sv
// rtl/vga_buf_arbiter_if.sv - CPU store-path req/ack bundle into the video buffer arbiter
interface vga_buf_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata
    );
endinterface

// File: rtl/vga_buf_guard.sv
// rtl/vga_buf_guard.sv - combinational test of a word address against the buffer under scan
module vga_buf_guard
    import vga_buf_arbiter_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic [AW-1:0] addr,
    input  logic          front_sel,
    output logic          in_front
);
    logic [AW:0] lo;
    logic [AW:0] hi;

    // One extra bit so the end of a buffer at the top of the map cannot wrap.
    always_comb begin
        lo       = front_sel ? (AW+1)'(VGA_BUF2_START) : (AW+1)'(VGA_BUF1_START);
        hi       = lo + (AW+1)'(VGA_BUF_WORDS);
        in_front = ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
    end
endmodule

// File: rtl/vga_buf_arbiter.sv
// rtl/vga_buf_arbiter.sv - video buffer RAM port arbiter (VGA priority, CPU in free slots); VGA_ARB_GUARD_EN blocks CPU writes to the front buffer
module vga_buf_arbiter
    import vga_buf_arbiter_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic                CLK33MHz,
    input  logic                RST_N,
    input  logic                vga_req,
    input  logic [AW-1:0]       RADDR_VGA,
    output logic [DW-1:0]       DATA_OUT_VGA,
    input  logic                front_sel,
    vga_buf_arbiter_if.slave    cpu,
    output logic [AW-1:0]       ram_addr,
    output logic                ram_we,
    output logic [DW-1:0]       ram_wdata,
    input  logic [DW-1:0]       ram_rdata
);
    arb_state_e    state_q, state_d;
    logic [AW-1:0] last_addr_q, last_addr_d;
    logic          last_valid_q, last_valid_d;
    logic          vga_pend_q, vga_pend_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          ack_rd_q, ack_rd_d;
    logic [DW-1:0] data_out_vga_q, data_out_vga_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;
    logic          ram_we_d;
    logic          vga_fetch;
    logic          cpu_grant;
    logic          wr_blocked;

`ifdef VGA_ARB_GUARD_EN
    logic in_front;

    vga_buf_guard #(.AW(AW)) u_guard (
        .addr      (cpu.cpu_addr),
        .front_sel (front_sel),
        .in_front  (in_front)
    );

    assign wr_blocked = cpu.cpu_we && vga_req && in_front;
`else
    logic unused_front_sel;

    assign unused_front_sel = front_sel;
    assign wr_blocked       = 1'b0;
`endif

    always_comb begin
        vga_fetch = RST_N && vga_req && !(last_valid_q && (RADDR_VGA == last_addr_q));
        cpu_grant = RST_N && (state_q == ARB_IDLE) && cpu.cpu_req && !vga_fetch && !wr_blocked;

        state_d        = state_q;
        last_addr_d    = last_addr_q;
        last_valid_d   = vga_req ? last_valid_q : 1'b0;
        vga_pend_d     = vga_fetch;
        cpu_ack_d      = 1'b0;
        ack_rd_d       = 1'b0;
        data_out_vga_d = vga_pend_q ? ram_rdata : data_out_vga_q;
        ram_addr_d     = ram_addr_q;
        ram_wdata_d    = ram_wdata_q;
        ram_we_d       = 1'b0;

        if (vga_fetch) begin
            ram_addr_d   = RADDR_VGA;
            last_addr_d  = RADDR_VGA;
            last_valid_d = 1'b1;
        end else if (cpu_grant) begin
            ram_addr_d  = cpu.cpu_addr;
            ram_we_d    = cpu.cpu_we;
            ram_wdata_d = cpu.cpu_wdata;
            // Overwriting the cached scan word forces the next visible request to refetch.
            if (cpu.cpu_we && (cpu.cpu_addr == last_addr_q)) begin
                last_valid_d = 1'b0;
            end
        end

        case (state_q)
            ARB_IDLE: begin
                if (cpu_grant) begin
                    state_d   = ARB_CPU_ACK;
                    cpu_ack_d = 1'b1;
                    ack_rd_d  = !cpu.cpu_we;
                end
            end
            ARB_CPU_ACK: state_d = ARB_IDLE;
            default:     state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge CLK33MHz) begin
        if (!RST_N) begin
            state_q        <= ARB_IDLE;
            last_addr_q    <= '0;
            last_valid_q   <= 1'b0;
            vga_pend_q     <= 1'b0;
            cpu_ack_q      <= 1'b0;
            ack_rd_q       <= 1'b0;
            data_out_vga_q <= '0;
            ram_addr_q     <= '0;
            ram_wdata_q    <= '0;
        end else begin
            state_q        <= state_d;
            last_addr_q    <= last_addr_d;
            last_valid_q   <= last_valid_d;
            vga_pend_q     <= vga_pend_d;
            cpu_ack_q      <= cpu_ack_d;
            ack_rd_q       <= ack_rd_d;
            data_out_vga_q <= data_out_vga_d;
            ram_addr_q     <= ram_addr_d;
            ram_wdata_q    <= ram_wdata_d;
        end
    end

    // The RAM samples its address this cycle, so the port is driven combinationally.
    assign ram_addr      = RST_N ? ram_addr_d  : '0;
    assign ram_wdata     = RST_N ? ram_wdata_d : '0;
    assign ram_we        = ram_we_d;
    assign DATA_OUT_VGA  = data_out_vga_q;
    assign cpu.cpu_ack   = cpu_ack_q;
    assign cpu.cpu_rdata = ack_rd_q ? ram_rdata : '0;
endmodule

// File: tb/tb_vga_buf_arbiter.sv
// tb/tb_vga_buf_arbiter.sv - directed scoreboard bench for vga_buf_arbiter
module tb_vga_buf_arbiter;
    import vga_buf_arbiter_pkg::*;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } cpu_txn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vga_req;
    logic [15:0] raddr_vga;
    logic [15:0] data_out_vga;
    logic        front_sel;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;

    logic        pl_we;
    logic [15:0] pl_addr;
    logic [15:0] pl_data;
    logic [15:0] mem [0:65535];
    logic [15:0] prev_addr;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int vga_reads = 0;

    cpu_txn_t stim_q[$];
    cpu_txn_t exp_q[$];
    int       ack_cyc[$];

    vga_buf_arbiter_if #(.AW(16), .DW(16)) cpu_bus ();

    vga_buf_arbiter #(.AW(16), .DW(16)) dut (
        .CLK33MHz     (clk),
        .RST_N        (rst_n),
        .vga_req      (vga_req),
        .RADDR_VGA    (raddr_vga),
        .DATA_OUT_VGA (data_out_vga),
        .front_sel    (front_sel),
        .cpu          (cpu_bus),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
        if (rst_n && vga_req && !ram_we && ram_addr == raddr_vga && ram_addr != prev_addr)
            vga_reads <= vga_reads + 1;
        prev_addr <= ram_addr;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_ack(input int max_cyc, output int lat);
        cpu_txn_t t;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!cpu_bus.cpu_ack && lat < max_cyc);
        t = exp_q.pop_front();
        chk("cpu_ack_seen", {31'd0, cpu_bus.cpu_ack}, 32'd1);
        if (cpu_bus.cpu_ack) begin
            ack_cyc.push_back(cyc);
            if (t.we) chk("mem_after_write", {16'd0, mem[t.addr]}, {16'd0, t.data});
            else      chk("cpu_rdata", {16'd0, cpu_bus.cpu_rdata}, {16'd0, t.data});
        end
    endtask

    task automatic cpu_run();
        cpu_txn_t t;
        int lat;
        while (stim_q.size() > 0) begin
            t = stim_q.pop_front();
            cpu_bus.cpu_req   = 1'b1;
            cpu_bus.cpu_we    = t.we;
            cpu_bus.cpu_addr  = t.addr;
            cpu_bus.cpu_wdata = t.data;
            exp_q.push_back(t);
            wait_ack(20, lat);
        end
        cpu_bus.cpu_req = 1'b0;
    endtask

    task automatic vga_stream();
        logic [15:0] addrs [6];
        addrs = '{16'h0100, 16'h0100, 16'h0101, 16'h0101, 16'h0101, 16'h0101};
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 2 || k == 3) chk("vga_word0", {16'd0, data_out_vga}, 32'hA1B2);
            else if (k >= 4)      chk("vga_word1", {16'd0, data_out_vga}, 32'hC3D4);
            vga_req   = 1'b1;
            raddr_vga = addrs[k];
        end
    endtask

    initial begin
        int lat;
        int r0;
        int base;
        int c0;
        logic [15:0] pl_a [3];
        logic [15:0] pl_d [3];
        pl_a = '{16'h0100, 16'h0101, 16'h2000};
        pl_d = '{16'hA1B2, 16'hC3D4, 16'h5555};

        rst_n = 1'b0; vga_req = 1'b0; raddr_vga = '0; front_sel = 1'b1; pl_we = 1'b0;
        pl_addr = '0; pl_data = '0;
        cpu_bus.cpu_req = 1'b0; cpu_bus.cpu_we = 1'b0; cpu_bus.cpu_addr = '0; cpu_bus.cpu_wdata = '0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pl_we = 1'b1; pl_addr = pl_a[i]; pl_data = pl_d[i];
        end
        @(negedge clk);
        pl_we = 1'b0;

        // Reset with a CPU read held pending
        cpu_bus.cpu_req = 1'b1; cpu_bus.cpu_we = 1'b0; cpu_bus.cpu_addr = 16'h2000;
        exp_q.push_back('{we: 1'b0, addr: 16'h2000, data: 16'h5555});
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_cpu_ack",   {31'd0, cpu_bus.cpu_ack}, 32'd0);
            chk("rst_cpu_rdata", {16'd0, cpu_bus.cpu_rdata}, 32'd0);
            chk("rst_data_vga",  {16'd0, data_out_vga}, 32'd0);
            chk("rst_ram_addr",  {16'd0, ram_addr}, 32'd0);
            chk("rst_ram_we",    {31'd0, ram_we}, 32'd0);
            chk("rst_ram_wdata", {16'd0, ram_wdata}, 32'd0);
        end
        rst_n = 1'b1;
        wait_ack(5, lat);
        chk("rst_ack_latency_le2", {31'd0, (lat <= 2)}, 32'd1);
        cpu_bus.cpu_req = 1'b0;

        // VGA fetch and word reuse
        @(negedge clk);
        r0 = vga_reads;
        vga_stream();
        @(negedge clk);
        chk("vga_ram_reads", vga_reads - r0, 32'd2);

        // CPU read served in the reuse slot
        vga_req = 1'b0;
        @(negedge clk);
        base = cyc;
        ack_cyc.delete();
        fork
            vga_stream();
            begin
                stim_q.push_back('{we: 1'b0, addr: 16'h2000, data: 16'h5555});
                cpu_run();
            end
        join
        chk("reuse_ack_cycle", (ack_cyc.size() > 0) ? ack_cyc[0] - base : -1, 32'd2);

        // Coherency: CPU overwrites the cached scan word
        @(negedge clk);
        vga_req = 1'b0;
        @(negedge clk);
        vga_req = 1'b1; raddr_vga = 16'h0100;
        repeat (3) @(negedge clk);
        chk("coh_before", {16'd0, data_out_vga}, 32'hA1B2);
        stim_q.push_back('{we: 1'b1, addr: 16'h0100, data: 16'hFFFF});
        cpu_run();
        repeat (3) @(negedge clk);
        chk("coh_refetch", {16'd0, data_out_vga}, 32'hFFFF);

        // Blanking: four back-to-back writes
        @(negedge clk);
        vga_req = 1'b0;
        ack_cyc.delete();
        for (int i = 0; i < 4; i++)
            stim_q.push_back('{we: 1'b1, addr: 16'h3000 + 16'(i), data: 16'h1111 * 16'(i + 1)});
        cpu_run();
        chk("blank_ack_count", ack_cyc.size(), 32'd4);
        for (int i = 1; i < ack_cyc.size(); i++)
            chk("blank_ack_spacing", ack_cyc[i] - ack_cyc[i-1], 32'd2);
        for (int i = 0; i < 4; i++)
            chk("blank_mem", {16'd0, mem[16'h3000 + 16'(i)]}, {16'd0, 16'h1111 * 16'(i + 1)});

`ifdef VGA_ARB_GUARD_EN
        // Front-buffer write guard
        @(negedge clk);
        vga_req = 1'b1; raddr_vga = 16'h0000; front_sel = 1'b0;
        repeat (2) @(negedge clk);
        ack_cyc.delete();
        c0 = cyc;
        stim_q.push_back('{we: 1'b1, addr: 16'(VGA_BUF2_START), data: 16'h2222});
        cpu_run();
        chk("guard_back_ack_latency", (ack_cyc.size() > 0) ? ack_cyc[0] - c0 : -1, 32'd1);
        cpu_bus.cpu_req = 1'b1; cpu_bus.cpu_we = 1'b1;
        cpu_bus.cpu_addr = 16'(VGA_BUF1_START + 5); cpu_bus.cpu_wdata = 16'h7777;
        exp_q.push_back('{we: 1'b1, addr: 16'(VGA_BUF1_START + 5), data: 16'h7777});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("guard_blocked", {31'd0, cpu_bus.cpu_ack}, 32'd0);
        end
        front_sel = 1'b1;
        wait_ack(2, lat);
        cpu_bus.cpu_req = 1'b0;
`else
        c0 = 0;
`endif

        @(negedge clk);
        vga_req = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
